// File: rtl/fft8_ctrl.sv
// fft8_ctrl: butterfly scheduler for the 8-point radix-2 DIT FFT core.
// Walks 3 stages x 4 butterflies. Each butterfly is one read, BF_LAT-1
// wait cycles and one in-place write-back. The scheduler also supplies
// the twiddle index for each butterfly.
module fft8_ctrl #(
    parameter int unsigned BF_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       initial_flag,
    output logic       rd_en,
    output logic [2:0] rd_add1,
    output logic [2:0] rd_add2,
    output logic [1:0] tw_idx,
    output logic       wr_en,
    output logic [2:0] wr_add1,
    output logic [2:0] wr_add2,
    output logic [1:0] stage,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W     = 4;
    localparam bit          SKIP_CALC = (BF_LAT == 1);
    localparam logic [CNT_W-1:0] CALC_LAST = (BF_LAT > 1) ? CNT_W'(BF_LAT - 2) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_READ,
        S_CALC,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       k_q, k_d;
    logic [1:0]       stage_d;
    logic             rd_en_d, wr_en_d, busy_d, done_d;
    logic [2:0]       rd_add1_d, rd_add2_d, wr_add1_d, wr_add2_d;
    logic [1:0]       tw_idx_d;

    // Operand pair and twiddle for butterfly k of stage st: {a, b, tw}.
    function automatic logic [7:0] bf_addr(input logic [1:0] st, input logic [1:0] kk);
        logic [2:0] a;
        logic [2:0] span;
        logic [1:0] tw;
        case (st)
            2'd0: begin
                a    = {kk, 1'b0};
                span = 3'd1;
                tw   = 2'd0;
            end
            2'd1: begin
                a    = {kk[1], 1'b0, kk[0]};
                span = 3'd2;
                tw   = {kk[0], 1'b0};
            end
            default: begin
                a    = {1'b0, kk};
                span = 3'd4;
                tw   = kk;
            end
        endcase
        return {a, 3'(a + span), tw};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = initial_flag ? S_READ : S_WAIT_INIT;
            S_WAIT_INIT: if (initial_flag) state_d = S_READ;
            S_READ:      state_d = SKIP_CALC ? S_WRITE : S_CALC;
            S_CALC:      if (cnt_q == CALC_LAST) state_d = S_WRITE;
            S_WRITE:     state_d = (k_q == 2'd3 && stage == 2'd2) ? S_FINISH : S_READ;
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output and counter next values; strobes are decoded from the next state
    // so the registered outputs line up with the state they belong to.
    always_comb begin
        cnt_d     = cnt_q;
        k_d       = k_q;
        stage_d   = stage;
        rd_en_d   = (state_d == S_READ);
        wr_en_d   = (state_d == S_WRITE);
        done_d    = (state_d == S_FINISH);
        busy_d    = (state_d != S_IDLE);
        rd_add1_d = rd_add1;
        rd_add2_d = rd_add2;
        tw_idx_d  = tw_idx;
        wr_add1_d = wr_add1;
        wr_add2_d = wr_add2;
        case (state_q)
            S_IDLE: begin
                k_d     = 2'd0;
                stage_d = 2'd0;
            end
            S_READ:  cnt_d = '0;
            S_CALC:  cnt_d = cnt_q + CNT_W'(1);
            S_WRITE: begin
                if (k_q != 2'd3) begin
                    k_d = k_q + 2'd1;
                end else if (stage != 2'd2) begin
                    stage_d = stage + 2'd1;
                    k_d     = 2'd0;
                end
            end
            default: ;
        endcase
        if (state_d == S_READ) {rd_add1_d, rd_add2_d, tw_idx_d} = bf_addr(stage_d, k_d);
        if (state_d == S_WRITE) begin
            wr_add1_d = rd_add1;
            wr_add2_d = rd_add2;
        end
    end

    // Registered outputs and butterfly counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            k_q     <= '0;
            stage   <= '0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            rd_add1 <= '0;
            rd_add2 <= '0;
            tw_idx  <= '0;
            wr_add1 <= '0;
            wr_add2 <= '0;
        end else begin
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            stage   <= stage_d;
            rd_en   <= rd_en_d;
            wr_en   <= wr_en_d;
            done    <= done_d;
            busy    <= busy_d;
            rd_add1 <= rd_add1_d;
            rd_add2 <= rd_add2_d;
            tw_idx  <= tw_idx_d;
            wr_add1 <= wr_add1_d;
            wr_add2 <= wr_add2_d;
        end
    end

endmodule

// File: tb/tb_fft8_ctrl.sv
// Bench for fft8_ctrl: one instance with BF_LAT=3, one with BF_LAT=1.
module tb_fft8_ctrl;

    localparam int unsigned LAT_A = 3;
    localparam int unsigned LAT_B = 1;

    logic clk = 1'b0;
    logic rst, start, initial_flag, dsel;
    logic start_a, start_b;

    logic       a_rd_en, a_wr_en, a_busy, a_done, b_rd_en, b_wr_en, b_busy, b_done;
    logic [2:0] a_ra1, a_ra2, a_wa1, a_wa2, b_ra1, b_ra2, b_wa1, b_wa2;
    logic [1:0] a_tw, a_stage, b_tw, b_stage;

    logic       m_rd_en, m_wr_en, m_busy, m_done;
    logic [2:0] m_ra1, m_ra2, m_wa1, m_wa2;
    logic [1:0] m_tw, m_stage;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~dsel;
    assign start_b = start & dsel;

    assign m_rd_en = dsel ? b_rd_en : a_rd_en;
    assign m_wr_en = dsel ? b_wr_en : a_wr_en;
    assign m_busy  = dsel ? b_busy  : a_busy;
    assign m_done  = dsel ? b_done  : a_done;
    assign m_ra1   = dsel ? b_ra1   : a_ra1;
    assign m_ra2   = dsel ? b_ra2   : a_ra2;
    assign m_wa1   = dsel ? b_wa1   : a_wa1;
    assign m_wa2   = dsel ? b_wa2   : a_wa2;
    assign m_tw    = dsel ? b_tw    : a_tw;
    assign m_stage = dsel ? b_stage : a_stage;

    fft8_ctrl #(.BF_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .initial_flag(initial_flag),
        .rd_en(a_rd_en), .rd_add1(a_ra1), .rd_add2(a_ra2), .tw_idx(a_tw),
        .wr_en(a_wr_en), .wr_add1(a_wa1), .wr_add2(a_wa2), .stage(a_stage),
        .busy(a_busy), .done(a_done)
    );

    fft8_ctrl #(.BF_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .initial_flag(initial_flag),
        .rd_en(b_rd_en), .rd_add1(b_ra1), .rd_add2(b_ra2), .tw_idx(b_tw),
        .wr_en(b_wr_en), .wr_add1(b_wa1), .wr_add2(b_wa2), .stage(b_stage),
        .busy(b_busy), .done(b_done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference butterfly i (0..11): operand pair, twiddle and stage.
    task automatic exp_bf(input int i, output int ea, output int eb, output int etw, output int est);
        int k, span, pos, grp;
        est  = i / 4;
        k    = i % 4;
        span = 1 << est;
        pos  = k % span;
        grp  = k / span;
        ea   = grp * 2 * span + pos;
        eb   = ea + span;
        etw  = pos * (4 / span);
    endtask

    // Follows one pass cycle by cycle; start must be set so the next edge accepts it.
    task automatic check_pass(input int lat, input int hold_from, input bit noise, input string tag);
        int per, last_wr, dcyc, bi, ph, ea, eb, etw, est;
        logic [3:0] e_ctl;
        per     = lat + 1;
        last_wr = 12 * per;
        dcyc    = last_wr + 1;
        for (int t = 1; t <= dcyc + 1; t++) begin
            step;
            bi = (t - 1) / per;
            ph = (t - 1) % per;
            if (hold_from >= 0 && bi >= hold_from) start = 1'b1;
            else if (noise && t < dcyc)            start = 1'($urandom_range(0, 1));
            else                                    start = 1'b0;
            if (noise && t < dcyc) initial_flag = 1'($urandom_range(0, 1));
            else                   initial_flag = 1'b1;

            e_ctl = {(t <= last_wr && ph == 0), (t <= last_wr && ph == lat), (t <= dcyc), (t == dcyc)};
            n_tests++;
            if ({m_rd_en, m_wr_en, m_busy, m_done} !== e_ctl) begin
                n_fail++;
                $display("FAIL %s ctl t=%0d {rd,wr,busy,done} got %b want %b", tag, t,
                         {m_rd_en, m_wr_en, m_busy, m_done}, e_ctl);
            end
            n_tests++;
            if ((m_rd_en & m_wr_en) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s overlap t=%0d rd_en&wr_en got %b want 0", tag, t, m_rd_en & m_wr_en);
            end
            if (t <= last_wr) begin
                exp_bf(bi, ea, eb, etw, est);
                n_tests++;
                if ({m_ra1, m_ra2, m_tw, m_stage} !== {3'(ea), 3'(eb), 2'(etw), 2'(est)}) begin
                    n_fail++;
                    $display("FAIL %s rd t=%0d bf=%0d got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                             tag, t, bi, m_ra1, m_ra2, m_tw, m_stage, ea, eb, etw, est);
                end
                if (ph == lat) begin
                    n_tests++;
                    if ({m_wa1, m_wa2} !== {3'(ea), 3'(eb)}) begin
                        n_fail++;
                        $display("FAIL %s wr t=%0d bf=%0d got a=%0d b=%0d want a=%0d b=%0d",
                                 tag, t, bi, m_wa1, m_wa2, ea, eb);
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        dsel = 1'b0; rst = 1'b1; start = 1'b0; initial_flag = 1'b0;
        repeat (3) step;
        n_tests++;
        if ({a_rd_en, a_wr_en, a_busy, a_done, a_ra1, a_ra2, a_tw, a_wa1, a_wa2, a_stage} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_a outputs got %h want 0",
                     {a_rd_en, a_wr_en, a_busy, a_done, a_ra1, a_ra2, a_tw, a_wa1, a_wa2, a_stage});
        end
        n_tests++;
        if ({b_rd_en, b_wr_en, b_busy, b_done, b_ra1, b_ra2, b_tw, b_wa1, b_wa2, b_stage} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_b outputs got %h want 0",
                     {b_rd_en, b_wr_en, b_busy, b_done, b_ra1, b_ra2, b_tw, b_wa1, b_wa2, b_stage});
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_basic_pass;
        dsel = 1'b0; initial_flag = 1'b1; start = 1'b1;
        check_pass(LAT_A, -1, 1'b0, "basic");
    endtask

    task automatic test_wait_init(input int w);
        dsel = 1'b0; initial_flag = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < w; i++) begin
            n_tests++;
            if ({m_busy, m_rd_en, m_wr_en} !== 3'b100) begin
                n_fail++;
                $display("FAIL wait_init cyc=%0d {busy,rd,wr} got %b want 100", i, {m_busy, m_rd_en, m_wr_en});
            end
            if (i < w - 1) step;
        end
        initial_flag = 1'b1;
        check_pass(LAT_A, -1, 1'b0, "wait_init");
    endtask

    task automatic test_random_passes(input int lat, input string tag);
        int gap;
        for (int r = 0; r < 3; r++) begin
            start = 1'b0; initial_flag = 1'b1;
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) begin
                step;
                n_tests++;
                if ({m_busy, m_rd_en} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s idle {busy,rd} got %b want 00", tag, {m_busy, m_rd_en});
                end
            end
            start = 1'b1;
            check_pass(lat, -1, 1'b1, tag);
        end
    endtask

    task automatic test_back_to_back;
        dsel = 1'b0; initial_flag = 1'b1; start = 1'b1;
        check_pass(LAT_A, 5, 1'b0, "hold_first");
        check_pass(LAT_A, -1, 1'b0, "hold_second");
    endtask

    task automatic test_reset_mid;
        int per, stop;
        per  = LAT_A + 1;
        stop = 1 + 6 * per + int'($urandom_range(0, LAT_A));
        dsel = 1'b0; initial_flag = 1'b1; start = 1'b1;
        for (int t = 1; t <= stop; t++) begin
            step;
            start = 1'b0;
        end
        n_tests++;
        if ({m_stage, m_ra1, m_ra2, m_busy} !== {2'd1, 3'd4, 3'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid pre st=%0d a=%0d b=%0d busy=%b want st=1 a=4 b=6 busy=1",
                     m_stage, m_ra1, m_ra2, m_busy);
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        n_tests++;
        if ({a_rd_en, a_wr_en, a_busy, a_done, a_ra1, a_ra2, a_tw, a_wa1, a_wa2, a_stage} !== 20'd0) begin
            n_fail++;
            $display("FAIL rst_mid outputs got %h want 0",
                     {a_rd_en, a_wr_en, a_busy, a_done, a_ra1, a_ra2, a_tw, a_wa1, a_wa2, a_stage});
        end
        for (int i = 0; i < 5; i++) begin
            step;
            n_tests++;
            if ({m_rd_en, m_wr_en, m_busy, m_done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rst_mid quiet cyc=%0d {rd,wr,busy,done} got %b want 0000",
                         i, {m_rd_en, m_wr_en, m_busy, m_done});
            end
        end
        start = 1'b1;
        check_pass(LAT_A, -1, 1'b0, "rst_restart");
    endtask

    task automatic test_lat1;
        dsel = 1'b1; initial_flag = 1'b1; start = 1'b1;
        check_pass(LAT_B, -1, 1'b0, "lat1");
        test_random_passes(LAT_B, "lat1_rand");
        start = 1'b0;
        dsel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic_pass;
        test_wait_init(10);
        test_wait_init(int'($urandom_range(1, 20)));
        dsel = 1'b0;
        test_random_passes(LAT_A, "rand");
        test_back_to_back;
        test_reset_mid;
        test_lat1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft8_ctrl.md
# fft8_ctrl

Butterfly scheduler for the 8-point radix-2 DIT FFT core. Once the data RAM reports bit-reversal initialisation complete, it steps through 3 stages × 4 butterflies. For each butterfly it issues the RAM read (two operand addresses), holds off while the butterfly unit computes, then issues the in-place write-back to the same two addresses. It also supplies the twiddle index, so RAM, butterfly and twiddle ROM need no sequencing logic of their own.

## Interface
Parameters:
- BF_LAT, 3: cycles from the rd_en cycle to valid butterfly results at the RAM write inputs; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one full FFT pass; sampled only in IDLE.
- initial_flag  input  1  from data RAM: input load and bit-reversal complete (level).
- rd_en  output  1  one-cycle read strobe to data RAM.
- rd_add1  output  3  butterfly upper-operand (a) address.
- rd_add2  output  3  butterfly lower-operand (b) address.
- tw_idx  output  2  twiddle index k, selecting W8^k (k = 0..3).
- wr_en  output  1  one-cycle write-back strobe to data RAM.
- wr_add1  output  3  write address for the a-result.
- wr_add2  output  3  write address for the b-result.
- stage  output  2  current stage, 0..2.
- busy  output  1  high from start acceptance until the done cycle (inclusive).
- done  output  1  one-cycle pulse: all 12 butterflies written back.

## Operation
- States: IDLE, WAIT_INIT, READ, CALC, WRITE, FINISH.
- IDLE: if start=1 and initial_flag=1, go to READ; if start=1 and initial_flag=0, go to WAIT_INIT. Clear stage and butterfly counter k.
- WAIT_INIT: stay until initial_flag=1, then go to READ. No timeout.
- READ: drive rd_en=1 for one cycle and latch rd_add1/2 and tw_idx. Go to CALC.
- CALC: count BF_LAT−1 cycles, then go to WRITE. With BF_LAT=1, CALC is skipped and READ goes straight to WRITE.
- WRITE: drive wr_en=1 for one cycle, with wr_add1/2 equal to the latched rd_add1/2. Advance the counters:
  - If k<3: k++ and return to READ.
  - Else if stage<2: stage++, k=0, return to READ.
  - Else: go to FINISH.
- FINISH: done=1 for one cycle, then return to IDLE.
- Address rule, with span = 1<<stage, pos = k & (span−1), grp = k >> stage:
  - a = grp·2·span + pos; b = a + span.
  - tw_idx = pos << (2−stage).
  - Stage 0 pairs: (0,1)(2,3)(4,5)(6,7), tw all 0.
  - Stage 1 pairs: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
  - Stage 2 pairs: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
- rd_en and wr_en are never high in the same cycle. The RAM gives read priority, so overlap would drop a write.
- start while busy is ignored. A start pulse held during FINISH is not accepted until IDLE.
- initial_flag dropping mid-pass is ignored; the pass completes.

## Timing
- Reset: state IDLE, and all outputs 0 (rd_en, wr_en, done, busy, stage, all addresses, tw_idx).
- A reset asserted mid-pass aborts the pass on the next edge. No further strobes are issued, and done is not produced.
- start accepted at edge N with initial_flag=1: busy=1 and rd_en=1 in cycle N+1.
- Per butterfly: READ 1 cycle + CALC (BF_LAT−1) cycles + WRITE 1 cycle = BF_LAT+1 cycles.
- wr_en occurs exactly BF_LAT cycles after its rd_en.
- Full pass: 12·(BF_LAT+1) cycles from the first rd_en to the last wr_en. done follows the last wr_en by 1 cycle. For BF_LAT=3, done is in cycle N+49.
- rd_add1/2, tw_idx and stage are registered, and hold their value from READ through WRITE.
- busy falls the cycle after done.

## Test plan
- Reset then start, initial_flag=1, BF_LAT=3 -> 12 rd_en pulses at 4-cycle spacing. Address/tw sequence matches the three stage lists above. done 49 cycles after start acceptance; busy low the next cycle.
- start with initial_flag=0 for 10 cycles, then 1 -> busy high during the wait, no rd_en until the cycle after initial_flag rises, then the normal 12-butterfly sequence.
- Every cycle of a full pass -> rd_en&wr_en never 1. Each wr_add1/2 pair equals the preceding rd_add1/2 pair, and wr_en lands exactly BF_LAT cycles after its rd_en.
- start re-pulsed at butterfly 5 and held high through FINISH -> ignored during the pass. A second pass starts from the IDLE cycle after done.
- rst asserted during stage 1, k=2 -> next cycle all outputs 0 and state IDLE. A subsequent start restarts at stage 0, pair (0,1).
- BF_LAT=1 build -> rd_en/wr_en alternate on consecutive cycles, 24 cycles from the first read to the last write, then done.
